// File: rtl/mux_sel_reg.sv
// Registered N:1 channel mux with valid/ready output, manual or round-robin select.
// A new word loads whenever the output register is empty or being consumed this cycle.
module mux_sel_reg #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic [SEL_W-1:0]              ptr;
  logic [SEL_W-1:0]              cand;
  logic [DATA_W-1:0]             pick_data;
  logic                          pick_valid;
  logic                          cand_ok;
  logic                          slot;

  assign ch_data = in;
  assign slot    = !out_valid || out_ready;
  assign cand    = mode ? ptr : sel;

  // One-hot match keeps the out-of-range select case free of array overrun.
  always_comb begin
    pick_data  = '0;
    pick_valid = 1'b0;
    cand_ok    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cand == SEL_W'(k)) begin
        pick_data  = ch_data[k];
        pick_valid = in_valid[k];
        cand_ok    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      ptr       <= '0;
    end else begin
      sel_err <= slot && !mode && !cand_ok;
      if (slot) begin
        out_valid <= cand_ok && pick_valid;
        if (cand_ok && pick_valid) begin
          out    <= pick_data;
          out_ch <= cand;
        end
        // Pointer steps every open slot in scan mode, even past idle channels.
        if (mode)
          ptr <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_reg.sv
// Bench for mux_sel_reg: an 8x8 instance and a 6x4 instance, both scoreboarded every cycle.
module tb_mux_sel_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-channel, 8-bit instance
  logic [7:0][7:0] d8;
  logic [63:0]     in8;
  logic [7:0]      iv8;
  logic            md8, rdy8;
  logic [2:0]      sl8;
  logic [7:0]      out8;
  logic            ov8, err8;
  logic [2:0]      och8;
  assign in8 = d8;

  // 6-channel, 4-bit instance
  logic [5:0][3:0] d6;
  logic [23:0]     in6;
  logic [5:0]      iv6;
  logic            md6, rdy6;
  logic [2:0]      sl6;
  logic [3:0]      out6;
  logic            ov6, err6;
  logic [2:0]      och6;
  assign in6 = d6;

  mux_sel_reg #(.NUM_CH(8), .DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .in_valid(iv8), .mode(md8), .sel(sl8),
    .out(out8), .out_valid(ov8), .out_ready(rdy8), .out_ch(och8), .sel_err(err8));

  mux_sel_reg #(.NUM_CH(6), .DATA_W(4)) dut6 (
    .clk(clk), .rst(rst), .in(in6), .in_valid(iv6), .mode(md6), .sel(sl6),
    .out(out6), .out_valid(ov6), .out_ready(rdy6), .out_ch(och6), .sel_err(err6));

  typedef struct packed {
    logic [7:0] out;
    logic       vld;
    logic [2:0] ch;
    logic       err;
    logic [2:0] ptr;
  } st_t;

  typedef struct {
    string       tag;
    int          dut;
    logic [12:0] exp;
  } sb_t;

  sb_t  q[$];
  st_t  s8, s6;
  int   errors = 0;
  int   checks = 0;

  function automatic st_t nxt(st_t s, int nch, logic [7:0][7:0] d, logic [7:0] iv,
                              logic md, logic [2:0] sl, logic rdy);
    st_t n;
    int  c;
    n     = s;
    n.err = 1'b0;
    if (!s.vld || rdy) begin
      c     = md ? int'(s.ptr) : int'(sl);
      n.vld = 1'b0;
      if (!md && c >= nch) n.err = 1'b1;
      else if (c < nch && iv[c]) begin
        n.out = d[c];
        n.ch  = 3'(c);
        n.vld = 1'b1;
      end
      if (md) n.ptr = (int'(s.ptr) == nch - 1) ? 3'd0 : s.ptr + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [12:0] pk(st_t s);
    return {s.out, s.vld, s.ch, s.err};
  endfunction

  task automatic chk(string tag, logic [12:0] got, logic [12:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed={out,vld,ch,err}=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(string tag);
    st_t             e8, e6;
    logic [7:0][7:0] t6;
    sb_t             it;
    logic [12:0]     got;
    e8 = nxt(s8, 8, d8, iv8, md8, sl8, rdy8);
    t6 = '0;
    for (int k = 0; k < 6; k++) t6[k] = {4'h0, d6[k]};
    e6 = nxt(s6, 6, t6, {2'b00, iv6}, md6, sl6, rdy6);
    q.push_back('{tag: {tag, "/n8"}, dut: 0, exp: pk(e8)});
    q.push_back('{tag: {tag, "/n6"}, dut: 1, exp: pk(e6)});
    @(posedge clk); #1;
    while (q.size() > 0) begin
      it  = q.pop_front();
      got = (it.dut == 0) ? {out8, ov8, och8, err8} : {4'h0, out6, ov6, och6, err6};
      chk(it.tag, got, it.exp);
    end
    s8 = e8;
    s6 = e6;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "/n8"}, {out8, ov8, och8, err8}, 13'h0);
    chk({tag, "/n6"}, {4'h0, out6, ov6, och6, err6}, 13'h0);
  endtask

  initial begin
    s8 = '0; s6 = '0;
    for (int k = 0; k < 8; k++) d8[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 6; k++) d6[k] = 4'h8 + 4'(k);
    iv8 = 8'hFF; md8 = 1'b0; sl8 = 3'd0; rdy8 = 1'b1;
    iv6 = 6'h00; md6 = 1'b0; sl6 = 3'd0; rdy6 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_init");
    rst = 1'b0;

    // manual sweep 0..7, one transfer per cycle
    for (int k = 0; k < 8; k++) begin
      sl8 = 3'(k);
      step($sformatf("sweep_sel%0d", k));
    end

    // async reset mid-stream with out_valid=1
    #2 rst = 1'b1;
    #1 chk_reset("reset_async");
    s8 = '0; s6 = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // stall hold on channel 3
    sl8 = 3'd3; d8[3] = 8'hA5;
    step("stall_load");
    rdy8 = 1'b0; d8[3] = 8'h5A;
    for (int k = 0; k < 4; k++) step($sformatf("stall_hold%0d", k));
    rdy8 = 1'b1;
    step("stall_release");
    step("stall_reload");

    // auto-scan with gaps: channels 0,2,5,7 valid
    md8 = 1'b1; iv8 = 8'b1010_0101;
    for (int k = 0; k < 10; k++) step($sformatf("scan_gap%0d", k));

    // scan up to ptr=4 with all valid, then stall there
    iv8 = 8'hFF;
    for (int k = 0; k < 8 && s8.ptr != 3'd4; k++) step("scan_to4");
    rdy8 = 1'b0;
    for (int k = 0; k < 3; k++) step($sformatf("scan_stall%0d", k));
    md8 = 1'b0; sl8 = 3'd1; rdy8 = 1'b1;
    step("switch_manual");
    md8 = 1'b1;
    step("resume_scan");
    step("resume_scan2");

    // out-of-range select on the 6-channel instance
    iv6 = 6'h3F; sl6 = 3'd2;
    step("n6_load2");
    sl6 = 3'd6;
    step("n6_oor_open");
    sl6 = 3'd0;
    step("n6_oor_clear");
    sl6 = 3'd7;
    step("n6_oor7");
    sl6 = 3'd1; rdy6 = 1'b0;
    step("n6_load1");
    sl6 = 3'd6;
    step("n6_oor_stall");
    step("n6_oor_stall2");

    // scan wrap 5 -> 0 on the 6-channel instance
    rdy6 = 1'b1; md6 = 1'b1; iv6 = 6'b10_1101;
    for (int k = 0; k < 8; k++) step($sformatf("n6_scan%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
